// File: rtl/drawing_cmd_sequencer_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// drawing_cmd_sequencer_if
// Bundles the host-side command port and the demux-side four-phase port of
// the drawing command sequencer.
//   Host side : cmd_wr, cmd_in, data_in -> sequencer
//               cmd_full, cmd_count, overflow, busy <- sequencer
//   Demux side: de_req, de_cmd, de_data <- sequencer
//               de_ack -> sequencer (may be asynchronous)
// modport slave  : the sequencer's view
// modport master : the environment's view (host + demux)
// ---------------------------------------------------------------------------
interface drawing_cmd_sequencer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              cmd_wr;
    logic [2:0]        cmd_in;
    logic [DATA_W-1:0] data_in;
    logic              cmd_full;
    logic [CNT_W-1:0]  cmd_count;
    logic              overflow;
    logic              busy;
    logic              de_req;
    logic [2:0]        de_cmd;
    logic [DATA_W-1:0] de_data;
    logic              de_ack;

    modport slave (
        input  cmd_wr, cmd_in, data_in, de_ack,
        output cmd_full, cmd_count, overflow, busy, de_req, de_cmd, de_data
    );

    modport master (
        output cmd_wr, cmd_in, data_in, de_ack,
        input  cmd_full, cmd_count, overflow, busy, de_req, de_cmd, de_data
    );
endinterface

// File: rtl/drawing_cmd_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// drawing_cmd_sequencer
// Queues drawing commands from the host and issues them one at a time to the
// 8-way drawing demux over a four-phase req/ack handshake. de_cmd/de_data
// are loaded only when a request starts and stay stable until the next one.
// Ports:
//   clk    : system clock, all state on rising edge
//   reset  : synchronous active-high reset
//   bus    : drawing_cmd_sequencer_if.slave (host push port + demux port)
// ---------------------------------------------------------------------------
module drawing_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    drawing_cmd_sequencer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              req_q, req_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [2:0]        cmd_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic ack_s;
    logic full;
    logic pop;
    logic push;

    // de_ack resynchroniser; depth 0 uses the raw input.
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign ack_s = bus.de_ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= bus.de_ack;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign ack_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign full = (count_q == CNT_W'(DEPTH));
    // The head leaves the FIFO only once the demux has released its ack.
    assign pop  = (state_q == S_REL) && !ack_s;
    // A pop on the same edge frees the slot, so a push at full still fits.
    assign push = bus.cmd_wr && (!full || pop);

    // NOTE: storage has no reset; the count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem_q[wr_ptr_q]  <= bus.cmd_in;
            data_mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (bus.cmd_wr && full && !pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    cmd_d   = cmd_mem_q[rd_ptr_q];
                    data_d  = data_mem_q[rd_ptr_q];
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!ack_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            cmd_q      <= '0;
            data_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.cmd_full  = full;
    assign bus.cmd_count = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state_q != S_IDLE) || (count_q != '0);
    assign bus.de_req    = req_q;
    assign bus.de_cmd    = cmd_q;
    assign bus.de_data   = data_q;
endmodule

// File: tb/tb_drawing_cmd_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_drawing_cmd_sequencer
// Self-checking bench for drawing_cmd_sequencer. A behavioural model built
// from queues tracks accepted commands, the handshake phase and the expected
// issue order; directed scenario tasks add their own timing checks.
// ---------------------------------------------------------------------------
module tb_drawing_cmd_sequencer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int SYNC   = 2;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    drawing_cmd_sequencer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    drawing_cmd_sequencer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .SYNC_STAGES(SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    entry_t         m_q[$];        // commands held by the block (incl. in flight)
    entry_t         exp_issue[$];  // accepted commands not yet seen on de_req
    entry_t         issued_log[$]; // commands seen rising on de_req
    entry_t         m_head = '0;   // what de_cmd/de_data should show
    int             m_phase = 0;   // 0 waiting, 1 requesting, 2 releasing
    logic           m_ovf = 1'b0;
    int             m_acc = 0;
    int             n_issued = 0;
    bit [SYNC-1:0]  ack_pipe = '0;
    bit             mon_en = 1'b0;
    logic           req_prev = 1'b0;

    always @(posedge clk) begin : model
        bit     ack_seen;
        bit     pop_now;
        bit     full_now;
        int     phase_n;
        entry_t e;
        if (reset) begin
            m_q.delete();
            exp_issue.delete();
            m_head   = '0;
            m_phase  = 0;
            m_ovf    = 1'b0;
            ack_pipe = '0;
        end else begin
            ack_seen = ack_pipe[SYNC-1];
            pop_now  = (m_phase == 2) && !ack_seen;
            full_now = (m_q.size() == DEPTH);
            phase_n  = m_phase;
            if (m_phase == 0 && m_q.size() != 0) begin
                m_head  = m_q[0];
                phase_n = 1;
            end else if (m_phase == 1 && ack_seen) begin
                phase_n = 2;
            end else if (m_phase == 2 && !ack_seen) begin
                phase_n = 0;
            end
            if (pop_now) void'(m_q.pop_front());
            if (bus.cmd_wr === 1'b1) begin
                e.cmd  = bus.cmd_in;
                e.data = bus.data_in;
                if (!full_now || pop_now) begin
                    m_q.push_back(e);
                    exp_issue.push_back(e);
                    m_acc++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_phase  = phase_n;
            ack_pipe = {ack_pipe[SYNC-2:0], bus.de_ack};
        end
    end

    // Continuous comparison of the DUT against the model, 1 time unit after
    // each rising edge.
    always @(posedge clk) begin : monitor
        entry_t got;
        entry_t want;
        logic   exp_req;
        logic   exp_busy;
        #1;
        got.cmd  = bus.de_cmd;
        got.data = bus.de_data;
        if (mon_en && !reset) begin
            exp_req  = (m_phase == 1);
            exp_busy = (m_phase != 0) || (m_q.size() != 0);
            total++;
            if (bus.de_req !== exp_req) begin
                bad++; $display("FAIL mon_de_req got=%0b want=%0b t=%0t", bus.de_req, exp_req, $time);
            end
            total++;
            if (bus.cmd_count !== CNT_W'(m_q.size())) begin
                bad++; $display("FAIL mon_count got=%0d want=%0d t=%0t", bus.cmd_count, m_q.size(), $time);
            end
            total++;
            if (bus.cmd_full !== (m_q.size() == DEPTH)) begin
                bad++; $display("FAIL mon_full got=%0b want=%0b t=%0t", bus.cmd_full, (m_q.size() == DEPTH), $time);
            end
            total++;
            if (bus.overflow !== m_ovf) begin
                bad++; $display("FAIL mon_overflow got=%0b want=%0b t=%0t", bus.overflow, m_ovf, $time);
            end
            total++;
            if (bus.busy !== exp_busy) begin
                bad++; $display("FAIL mon_busy got=%0b want=%0b t=%0t", bus.busy, exp_busy, $time);
            end
            total++;
            if (got !== m_head) begin
                bad++; $display("FAIL mon_cmd_data got=%0d/%h want=%0d/%h t=%0t", got.cmd, got.data, m_head.cmd, m_head.data, $time);
            end
            if (bus.de_req === 1'b1 && req_prev !== 1'b1) begin
                issued_log.push_back(got);
                n_issued++;
                total++;
                if (exp_issue.size() == 0) begin
                    bad++; $display("FAIL issue_unexpected got=%0d/%h want=none t=%0t", got.cmd, got.data, $time);
                end else begin
                    want = exp_issue.pop_front();
                    if (got !== want) begin
                        bad++; $display("FAIL issue_order got=%0d/%h want=%0d/%h t=%0t", got.cmd, got.data, want.cmd, want.data, $time);
                    end
                end
            end
        end
        req_prev = bus.de_req;
    end

    // ---------------- stimulus helpers (start and end at a negedge) ----------------
    task automatic push_one(input logic [2:0] c, input logic [DATA_W-1:0] d);
        bus.cmd_wr  = 1'b1;
        bus.cmd_in  = c;
        bus.data_in = d;
        @(negedge clk);
        bus.cmd_wr  = 1'b0;
    endtask

    task automatic wait_req(input logic level, output bit ok);
        int guard;
        guard = 0;
        while (bus.de_req !== level && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ok = (guard < 200);
    endtask

    task automatic serve(input int n, input int hold);
        bit ok;
        for (int k = 0; k < n; k++) begin
            wait_req(1'b1, ok);
            if (!ok) begin
                total++; bad++; $display("FAIL serve_req_timeout got=%0b want=1", bus.de_req);
                return;
            end
            repeat (hold) @(negedge clk);
            bus.de_ack = 1'b1;
            wait_req(1'b0, ok);
            if (!ok) begin
                total++; bad++; $display("FAIL serve_release_timeout got=%0b want=0", bus.de_req);
                bus.de_ack = 1'b0;
                return;
            end
            bus.de_ack = 1'b0;
            repeat (SYNC + 2) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        mon_en = 1'b1;
        total++; if (bus.de_req !== 1'b0)   begin bad++; $display("FAIL rst_de_req got=%0b want=0", bus.de_req); end
        total++; if (bus.de_cmd !== 3'd0)   begin bad++; $display("FAIL rst_de_cmd got=%0d want=0", bus.de_cmd); end
        total++; if (bus.de_data !== '0)    begin bad++; $display("FAIL rst_de_data got=%h want=0", bus.de_data); end
        total++; if (bus.cmd_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b want=0", bus.cmd_full); end
        total++; if (bus.cmd_count !== '0)  begin bad++; $display("FAIL rst_count got=%0d want=0", bus.cmd_count); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b want=0", bus.overflow); end
        total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%0b want=0", bus.busy); end
    endtask

    task automatic test_single();
        push_one(3'd5, 16'h1234);          // edge t between
        total++; if (bus.de_req !== 1'b0)  begin bad++; $display("FAIL single_req_early got=%0b want=0", bus.de_req); end
        total++; if (bus.cmd_count !== CNT_W'(1)) begin bad++; $display("FAIL single_count got=%0d want=1", bus.cmd_count); end
        @(negedge clk);                    // after edge t+1
        total++; if (bus.de_req !== 1'b1)  begin bad++; $display("FAIL single_req_latency got=%0b want=1", bus.de_req); end
        total++; if (bus.de_cmd !== 3'd5)  begin bad++; $display("FAIL single_de_cmd got=%0d want=5", bus.de_cmd); end
        total++; if (bus.de_data !== 16'h1234) begin bad++; $display("FAIL single_de_data got=%h want=1234", bus.de_data); end
        repeat (3) @(negedge clk);
        bus.de_ack = 1'b1;
        repeat (SYNC) @(negedge clk);
        total++; if (bus.de_req !== 1'b1)  begin bad++; $display("FAIL single_req_hold got=%0b want=1", bus.de_req); end
        @(negedge clk);
        total++; if (bus.de_req !== 1'b0)  begin bad++; $display("FAIL single_req_fall got=%0b want=0", bus.de_req); end
        bus.de_ack = 1'b0;
        repeat (SYNC) @(negedge clk);
        total++; if (bus.cmd_count !== CNT_W'(1)) begin bad++; $display("FAIL single_count_hold got=%0d want=1", bus.cmd_count); end
        @(negedge clk);
        total++; if (bus.cmd_count !== '0) begin bad++; $display("FAIL single_count_pop got=%0d want=0", bus.cmd_count); end
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL single_busy got=%0b want=0", bus.busy); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        issued_log.delete();
        for (int i = 0; i < 4; i++) begin
            bus.cmd_wr  = 1'b1;
            bus.cmd_in  = 3'(i);
            bus.data_in = 16'h0100 + 16'(i);
            @(negedge clk);
        end
        bus.cmd_wr = 1'b0;
        total++; if (bus.cmd_full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%0b want=1", bus.cmd_full); end
        total++; if (bus.cmd_count !== CNT_W'(4)) begin bad++; $display("FAIL b2b_count got=%0d want=4", bus.cmd_count); end
        serve(4, 2);
        total++;
        if (issued_log.size() != 4) begin
            bad++; $display("FAIL b2b_issued_n got=%0d want=4", issued_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (issued_log[i].cmd !== 3'(i) || issued_log[i].data !== 16'h0100 + 16'(i)) begin
                    bad++; $display("FAIL b2b_order[%0d] got=%0d/%h want=%0d/%h", i, issued_log[i].cmd, issued_log[i].data, i, 16'h0100 + 16'(i));
                end
            end
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%0b want=0", bus.busy); end
    endtask

    task automatic test_overflow();
        logic [2:0] want_cmds [5];
        bit ok;
        want_cmds = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
        issued_log.delete();
        for (int i = 4; i < 8; i++) begin
            bus.cmd_wr  = 1'b1;
            bus.cmd_in  = 3'(i);
            bus.data_in = 16'($urandom);
            @(negedge clk);
        end
        bus.cmd_wr = 1'b0;
        push_one(3'd1, 16'hdead);          // full, no pop: dropped
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", bus.overflow); end
        total++; if (bus.cmd_count !== CNT_W'(4)) begin bad++; $display("FAIL ovf_count got=%0d want=4", bus.cmd_count); end
        bus.de_ack = 1'b1;
        wait_req(1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_release_timeout got=%0b want=0", bus.de_req); end
        bus.de_ack = 1'b0;
        repeat (SYNC) @(negedge clk);
        push_one(3'd2, 16'hbeef);          // lands on the pop edge
        total++; if (bus.cmd_count !== CNT_W'(4)) begin bad++; $display("FAIL ovf_pop_push_count got=%0d want=4", bus.cmd_count); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", bus.overflow); end
        serve(4, 1);
        total++;
        if (issued_log.size() != 5) begin
            bad++; $display("FAIL ovf_issued_n got=%0d want=5", issued_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (issued_log[i].cmd !== want_cmds[i]) begin
                    bad++; $display("FAIL ovf_order[%0d] got=%0d want=%0d", i, issued_log[i].cmd, want_cmds[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rises;
        logic prev;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            bus.cmd_wr  = 1'b1;
            bus.cmd_in  = 3'(i);
            bus.data_in = 16'($urandom);
            @(negedge clk);
        end
        bus.cmd_wr = 1'b0;
        total++; if (bus.de_req !== 1'b1) begin bad++; $display("FAIL rmid_in_req got=%0b want=1", bus.de_req); end
        total++; if (bus.cmd_count !== CNT_W'(3)) begin bad++; $display("FAIL rmid_count_pre got=%0d want=3", bus.cmd_count); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.de_req !== 1'b0) begin bad++; $display("FAIL rmid_req_drop got=%0b want=0", bus.de_req); end
        total++; if (bus.cmd_count !== '0) begin bad++; $display("FAIL rmid_count got=%0d want=0", bus.cmd_count); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", bus.busy); end
        reset = 1'b0;
        rises = 0;
        prev  = bus.de_req;
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) bus.de_ack = ~bus.de_ack;
            @(negedge clk);
            if (bus.de_req === 1'b1 && prev !== 1'b1) rises++;
            prev = bus.de_req;
        end
        bus.de_ack = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        total++; if (rises != 0) begin bad++; $display("FAIL rmid_spurious_req got=%0d want=0", rises); end
    endtask

    task automatic test_long_ack();
        int rises;
        logic prev;
        bit ok;
        push_one(3'd3, 16'h0033);
        push_one(3'd6, 16'h0066);
        wait_req(1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL lack_req_timeout got=%0b want=1", bus.de_req); end
        bus.de_ack = 1'b1;
        rises = 0;
        prev  = bus.de_req;
        repeat (10) begin
            @(negedge clk);
            if (bus.de_req === 1'b1 && prev !== 1'b1) rises++;
            prev = bus.de_req;
        end
        total++; if (rises != 0) begin bad++; $display("FAIL lack_extra_req got=%0d want=0", rises); end
        total++; if (bus.de_req !== 1'b0) begin bad++; $display("FAIL lack_req_low got=%0b want=0", bus.de_req); end
        bus.de_ack = 1'b0;
        repeat (SYNC + 1) @(negedge clk);  // pop edge
        total++; if (bus.de_req !== 1'b0) begin bad++; $display("FAIL lack_next_early got=%0b want=0", bus.de_req); end
        total++; if (bus.cmd_count !== CNT_W'(1)) begin bad++; $display("FAIL lack_count got=%0d want=1", bus.cmd_count); end
        @(negedge clk);
        total++; if (bus.de_req !== 1'b1) begin bad++; $display("FAIL lack_next_req got=%0b want=1", bus.de_req); end
        total++; if (bus.de_cmd !== 3'd6) begin bad++; $display("FAIL lack_next_cmd got=%0d want=6", bus.de_cmd); end
        serve(1, 2);
    endtask

    task automatic test_random();
        int acc0;
        int iss0;
        int cyc;
        acc0 = m_acc;
        iss0 = n_issued;
        cyc  = 0;
        while ((m_acc - acc0 < 2000 || m_q.size() != 0 || m_phase != 0) && cyc < 60000) begin
            if (m_acc - acc0 < 2000 && $urandom_range(0, 2) != 0) begin
                bus.cmd_wr  = 1'b1;
                bus.cmd_in  = 3'($urandom);
                bus.data_in = 16'($urandom);
            end else begin
                bus.cmd_wr  = 1'b0;
            end
            if (bus.de_req === 1'b1 && bus.de_ack === 1'b0) begin
                if ($urandom_range(0, 2) == 0) bus.de_ack = 1'b1;
            end else if (bus.de_req === 1'b0 && bus.de_ack === 1'b1) begin
                if ($urandom_range(0, 2) == 0) bus.de_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.cmd_wr = 1'b0;
        bus.de_ack = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        total++; if (cyc >= 60000) begin bad++; $display("FAIL rand_timeout got=%0d want<60000", cyc); end
        total++; if (n_issued - iss0 != m_acc - acc0) begin bad++; $display("FAIL rand_issued_n got=%0d want=%0d", n_issued - iss0, m_acc - acc0); end
        total++; if (exp_issue.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", exp_issue.size()); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rand_busy got=%0b want=0", bus.busy); end
    endtask

    initial begin
        reset       = 1'b1;
        bus.cmd_wr  = 1'b0;
        bus.cmd_in  = '0;
        bus.data_in = '0;
        bus.de_ack  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_long_ack();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
